// File: rtl/bus_arbiter.sv
// Round-robin arbiter that shares one bus_controller port between NUM_MASTERS requesters.
// One transaction in flight, request fields latched at grant, timeout completes with error.
module bus_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      i_clock,
    input  logic                      i_reset_n,
    input  logic [NUM_MASTERS-1:0]    i_req_valid,
    input  logic [NUM_MASTERS-1:0]    i_req_write_enable,
    input  logic [32*NUM_MASTERS-1:0] i_req_address,
    input  logic [32*NUM_MASTERS-1:0] i_req_data_write,
    output logic [NUM_MASTERS-1:0]    o_req_ready,
    output logic                      o_req_error,
    output logic [31:0]               o_req_data_read,
    output logic [NUM_MASTERS-1:0]    o_grant,
    output logic                      o_bus_vaild,
    input  logic                      i_bus_ready,
    input  logic                      i_bus_busy,
    output logic                      o_bus_write_enable,
    output logic [31:0]               o_bus_address,
    input  logic [31:0]               i_bus_data_read,
    output logic [31:0]               o_bus_data_write,
    output logic                      o_arb_busy
);

    localparam int IW = $clog2(NUM_MASTERS);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_stateNext;

    logic [IW-1:0]          r_ptr;
    logic [IW-1:0]          r_index;
    logic [NUM_MASTERS-1:0] r_grant;
    logic                   r_write;
    logic [31:0]            r_address;
    logic [31:0]            r_dataWrite;
    logic [CW-1:0]          r_count;
    logic [31:0]            r_dataRead;
    logic                   r_error;

    logic                   w_anyValid;
    logic [NUM_MASTERS-1:0] w_rotated;
    logic [IW-1:0]          w_offset;
    logic [IW:0]            w_sum;
    logic [IW-1:0]          w_pickIndex;
    logic                   w_pickWrite;
    logic [31:0]            w_pickAddress;
    logic [31:0]            w_pickData;
    logic [IW:0]            w_ptrInc;
    logic [IW-1:0]          w_ptrNext;
    logic [CW:0]            w_countInc;
    logic                   w_timeout;
    logic                   w_busAccept;

    assign w_anyValid  = |i_req_valid;
    assign w_busAccept = i_bus_ready & ~i_bus_busy;
    assign w_countInc  = {1'b0, r_count} + (CW + 1)'(1);
    assign w_timeout   = (w_countInc == (CW + 1)'(TIMEOUT_CYCLES));
    assign w_ptrInc    = {1'b0, r_index} + (IW + 1)'(1);
    assign w_ptrNext   = (w_ptrInc == (IW + 1)'(NUM_MASTERS)) ? '0 : w_ptrInc[IW-1:0];

    // Rotate the request vector so bit 0 is the master at the pointer, then take the lowest set bit.
    always_comb begin
        w_rotated = NUM_MASTERS'({i_req_valid, i_req_valid} >> r_ptr);
        w_offset  = '0;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            if (w_rotated[k]) begin
                w_offset = IW'(k);
            end
        end
        w_sum = {1'b0, r_ptr} + {1'b0, w_offset};
        if (w_sum >= (IW + 1)'(NUM_MASTERS)) begin
            w_pickIndex = IW'(w_sum - (IW + 1)'(NUM_MASTERS));
        end else begin
            w_pickIndex = w_sum[IW-1:0];
        end
    end

    always_comb begin
        w_pickWrite   = 1'b0;
        w_pickAddress = '0;
        w_pickData    = '0;
        for (int m = 0; m < NUM_MASTERS; m++) begin
            if (w_pickIndex == IW'(m)) begin
                w_pickWrite   = i_req_write_enable[m];
                w_pickAddress = i_req_address[32*m +: 32];
                w_pickData    = i_req_data_write[32*m +: 32];
            end
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE:    if (w_anyValid) w_stateNext = REQ;
            REQ:     if (w_busAccept || w_timeout) w_stateNext = RESP;
            RESP:    w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    // A bus acceptance on the final timeout cycle still counts as a normal completion.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_ptr       <= '0;
            r_index     <= '0;
            r_grant     <= '0;
            r_write     <= 1'b0;
            r_address   <= '0;
            r_dataWrite <= '0;
            r_count     <= '0;
            r_dataRead  <= '0;
            r_error     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_count <= '0;
                    if (w_anyValid) begin
                        r_index     <= w_pickIndex;
                        r_grant     <= {{(NUM_MASTERS-1){1'b0}}, 1'b1} << w_pickIndex;
                        r_write     <= w_pickWrite;
                        r_address   <= w_pickAddress;
                        r_dataWrite <= w_pickData;
                    end
                end
                REQ: begin
                    r_count <= w_countInc[CW-1:0];
                    if (w_busAccept) begin
                        r_dataRead <= i_bus_data_read;
                        r_error    <= 1'b0;
                    end else if (w_timeout) begin
                        r_dataRead <= '0;
                        r_error    <= 1'b1;
                    end
                end
                RESP: begin
                    r_ptr   <= w_ptrNext;
                    r_count <= '0;
                    r_grant <= '0;
                end
                default: begin
                    r_count <= '0;
                    r_grant <= '0;
                end
            endcase
        end
    end

    always_comb begin
        o_bus_vaild        = (r_state == REQ);
        o_bus_write_enable = (r_state == REQ) ? r_write : 1'b0;
        o_bus_address      = (r_state == REQ) ? r_address : '0;
        o_bus_data_write   = (r_state == REQ) ? r_dataWrite : '0;
        o_req_ready        = (r_state == RESP) ? r_grant : '0;
        o_grant            = r_grant;
        o_arb_busy         = (r_state != IDLE);
        o_req_error        = r_error;
        o_req_data_read    = r_dataRead;
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: a transaction-level model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_bus_arbiter;

    localparam int N   = 2;
    localparam int TMO = 4;

    logic            i_clock = 1'b0;
    logic            i_reset_n = 1'b1;
    logic [N-1:0]    i_req_valid;
    logic [N-1:0]    i_req_write_enable;
    logic [32*N-1:0] i_req_address;
    logic [32*N-1:0] i_req_data_write;
    logic [N-1:0]    o_req_ready;
    logic            o_req_error;
    logic [31:0]     o_req_data_read;
    logic [N-1:0]    o_grant;
    logic            o_bus_vaild;
    logic            i_bus_ready;
    logic            i_bus_busy;
    logic            o_bus_write_enable;
    logic [31:0]     o_bus_address;
    logic [31:0]     i_bus_data_read;
    logic [31:0]     o_bus_data_write;
    logic            o_arb_busy;

    bus_arbiter #(.NUM_MASTERS(N), .TIMEOUT_CYCLES(TMO)) dut (
        .i_clock            (i_clock),
        .i_reset_n          (i_reset_n),
        .i_req_valid        (i_req_valid),
        .i_req_write_enable (i_req_write_enable),
        .i_req_address      (i_req_address),
        .i_req_data_write   (i_req_data_write),
        .o_req_ready        (o_req_ready),
        .o_req_error        (o_req_error),
        .o_req_data_read    (o_req_data_read),
        .o_grant            (o_grant),
        .o_bus_vaild        (o_bus_vaild),
        .i_bus_ready        (i_bus_ready),
        .i_bus_busy         (i_bus_busy),
        .o_bus_write_enable (o_bus_write_enable),
        .o_bus_address      (o_bus_address),
        .i_bus_data_read    (i_bus_data_read),
        .o_bus_data_write   (o_bus_data_write),
        .o_arb_busy         (o_arb_busy)
    );

    always #5 i_clock = ~i_clock;

    int testsRun = 0;
    int testsFailed = 0;
    int cycleCount = 0;
    int rem [N];
    logic [N-1:0] prevGrant = '0;
    logic [N-1:0] grantLog [$];
    logic [N-1:0] readyLog [$];

    // Transaction-level model: owner, rr pointer, cycles waited on the bus, completion data.
    int          mOwner = -1;
    int          mPtr = 0;
    int          mWaited = 0;
    int          mIdx = 0;
    bit          mRespond = 1'b0;
    logic        mWrite = 1'b0;
    logic [31:0] mAddr = '0;
    logic [31:0] mWdata = '0;
    logic [31:0] mData = '0;
    logic        mErr = 1'b0;

    logic         eValid;
    logic [N-1:0] eGrant;
    logic [N-1:0] eReady;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int m, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input int count);
        i_req_valid[m]                 = 1'b1;
        i_req_write_enable[m]          = we;
        i_req_address[32*m +: 32]      = addr;
        i_req_data_write[32*m +: 32]   = wdata;
        rem[m]                         = count;
    endtask

    // Advance to the next falling edge and play the requester side of the handshake.
    task automatic tick();
        @(negedge i_clock);
        cycleCount++;
        if (o_grant != '0 && prevGrant == '0) grantLog.push_back(o_grant);
        prevGrant = o_grant;
        for (int m = 0; m < N; m++) begin
            if (o_req_ready[m] && rem[m] > 0) begin
                readyLog.push_back(o_req_ready);
                rem[m]--;
                if (rem[m] == 0) i_req_valid[m] = 1'b0;
                else i_req_address[32*m +: 32] = i_req_address[32*m +: 32] + 32'd4;
            end
        end
    endtask

    task automatic resetPulse();
        #2 i_reset_n = 1'b0;
        @(negedge i_clock);
        #2 i_reset_n = 1'b1;
        tick();
    endtask

    initial forever begin
        @(posedge i_clock or negedge i_reset_n);
        if (!i_reset_n) begin
            mOwner = -1; mPtr = 0; mWaited = 0; mRespond = 1'b0;
            mData = '0; mErr = 1'b0; mWrite = 1'b0; mAddr = '0; mWdata = '0;
        end else if (mRespond) begin
            mPtr = (mOwner + 1) % N;
            mOwner = -1;
            mRespond = 1'b0;
        end else if (mOwner >= 0) begin
            mWaited++;
            if (i_bus_ready && !i_bus_busy) begin
                mData = i_bus_data_read; mErr = 1'b0; mRespond = 1'b1;
            end else if (mWaited == TMO) begin
                mData = '0; mErr = 1'b1; mRespond = 1'b1;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                mIdx = (mPtr + k) % N;
                if (mOwner < 0 && i_req_valid[mIdx]) begin
                    mOwner  = mIdx;
                    mWrite  = i_req_write_enable[mIdx];
                    mAddr   = i_req_address[32*mIdx +: 32];
                    mWdata  = i_req_data_write[32*mIdx +: 32];
                    mWaited = 0;
                end
            end
        end
    end

    initial forever begin
        @(negedge i_clock);
        eGrant = '0;
        eReady = '0;
        if (mOwner >= 0) eGrant[mOwner] = 1'b1;
        if (mRespond) eReady = eGrant;
        eValid = (mOwner >= 0) && !mRespond;
        checkOutput("cmp_vaild", 32'(o_bus_vaild), 32'(eValid));
        checkOutput("cmp_grant", 32'(o_grant), 32'(eGrant));
        checkOutput("cmp_ready", 32'(o_req_ready), 32'(eReady));
        checkOutput("cmp_busy", 32'(o_arb_busy), 32'(mOwner >= 0));
        checkOutput("cmp_error", 32'(o_req_error), 32'(mErr));
        checkOutput("cmp_rdata", o_req_data_read, mData);
        checkOutput("cmp_ready_onehot", 32'($countones(o_req_ready) <= 1), 32'd1);
        if (eValid) begin
            checkOutput("cmp_bus_we", 32'(o_bus_write_enable), 32'(mWrite));
            checkOutput("cmp_bus_addr", o_bus_address, mAddr);
            checkOutput("cmp_bus_wdata", o_bus_data_write, mWdata);
        end
    end

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation ran past %0t", $time);
        $fatal(1);
    end

    int vStart, rStart;
    logic [N-1:0] readyT4;
    logic errT4;
    logic [31:0] dataT4;

    initial begin
        i_req_valid = '0; i_req_write_enable = '0; i_req_address = '0; i_req_data_write = '0;
        i_bus_ready = 1'b1; i_bus_busy = 1'b0; i_bus_data_read = '0;
        rem[0] = 0; rem[1] = 0;
        #1 i_reset_n = 1'b0;
        #11;
        checkOutput("rst_vaild", 32'(o_bus_vaild), 32'd0);
        checkOutput("rst_grant", 32'(o_grant), 32'd0);
        checkOutput("rst_ready", 32'(o_req_ready), 32'd0);
        checkOutput("rst_busy", 32'(o_arb_busy), 32'd0);
        checkOutput("rst_rdata", o_req_data_read, 32'd0);
        #10 i_reset_n = 1'b1;
        tick();

        // Single read, zero-wait bus
        i_bus_data_read = 32'hABCD_EF01;
        applyStimulus(0, 1'b0, 32'h0000_FFF0, 32'h0, 1);
        tick();
        checkOutput("t1_vaild", 32'(o_bus_vaild), 32'd1);
        checkOutput("t1_addr", o_bus_address, 32'h0000_FFF0);
        checkOutput("t1_no_early_ready", 32'(o_req_ready), 32'd0);
        tick();
        checkOutput("t1_ready", 32'(o_req_ready), 32'h1);
        checkOutput("t1_rdata", o_req_data_read, 32'hABCD_EF01);
        checkOutput("t1_error", 32'(o_req_error), 32'd0);
        tick();
        checkOutput("t1_idle_grant", 32'(o_grant), 32'd0);

        // Both masters competing from reset, each asking twice
        resetPulse();
        grantLog.delete();
        readyLog.delete();
        i_bus_data_read = 32'h1111_2222;
        applyStimulus(0, 1'b0, 32'h0000_1000, 32'h0, 2);
        applyStimulus(1, 1'b0, 32'h0000_2000, 32'h0, 2);
        for (int i = 0; i < 40 && (rem[0] > 0 || rem[1] > 0); i++) tick();
        checkOutput("t2_done", 32'(rem[0] + rem[1]), 32'd0);
        checkOutput("t2_grant_count", 32'(grantLog.size()), 32'd4);
        checkOutput("t2_ready_count", 32'(readyLog.size()), 32'd4);
        for (int i = 0; i < 4 && i < grantLog.size() && i < readyLog.size(); i++) begin
            checkOutput($sformatf("t2_grant%0d", i), 32'(grantLog[i]), (i % 2 == 0) ? 32'h1 : 32'h2);
            checkOutput($sformatf("t2_ready%0d", i), 32'(readyLog[i]), (i % 2 == 0) ? 32'h1 : 32'h2);
        end
        tick();

        // Write from master 1
        i_bus_data_read = 32'h55AA_55AA;
        applyStimulus(1, 1'b1, 32'h0000_1234, 32'hDEAD_BEEF, 1);
        tick();
        checkOutput("t3_we", 32'(o_bus_write_enable), 32'd1);
        checkOutput("t3_addr", o_bus_address, 32'h0000_1234);
        checkOutput("t3_wdata", o_bus_data_write, 32'hDEAD_BEEF);
        checkOutput("t3_grant", 32'(o_grant), 32'h2);
        tick();
        checkOutput("t3_ready", 32'(o_req_ready), 32'h2);
        checkOutput("t3_rdata", o_req_data_read, 32'h55AA_55AA);
        tick();

        // Bus never answers: timeout; requester drops valid and edits fields mid-flight
        i_bus_ready = 1'b0;
        applyStimulus(0, 1'b0, 32'h0000_0040, 32'h0, 1);
        vStart = -1;
        rStart = -1;
        readyT4 = '0; errT4 = 1'b0; dataT4 = 32'hFFFF_FFFF;
        for (int i = 0; i < 20 && rStart < 0; i++) begin
            tick();
            if (o_bus_vaild && vStart >= 0 && cycleCount == vStart + 1)
                checkOutput("t4_addr_latched", o_bus_address, 32'h0000_0040);
            if (o_bus_vaild && vStart < 0) begin
                vStart = cycleCount;
                i_req_address[31:0] = 32'h0000_BAD0;
                i_req_valid[0] = 1'b0;
                rem[0] = 0;
            end
            if (o_req_ready != '0) begin
                rStart = cycleCount;
                readyT4 = o_req_ready;
                errT4 = o_req_error;
                dataT4 = o_req_data_read;
            end
        end
        checkOutput("t4_latency", 32'(rStart - vStart), 32'd4);
        checkOutput("t4_ready", 32'(readyT4), 32'h1);
        checkOutput("t4_error", 32'(errT4), 32'd1);
        checkOutput("t4_rdata", dataT4, 32'd0);
        i_bus_ready = 1'b1;
        i_bus_data_read = 32'h1357_9BDF;
        tick();
        applyStimulus(1, 1'b0, 32'h0000_0080, 32'h0, 1);
        tick();
        tick();
        checkOutput("t4_next_ready", 32'(o_req_ready), 32'h2);
        checkOutput("t4_next_error", 32'(o_req_error), 32'd0);
        checkOutput("t4_next_rdata", o_req_data_read, 32'h1357_9BDF);
        tick();

        // Busy stall; acceptance lands on the timeout cycle and must win
        i_bus_busy = 1'b1;
        i_bus_data_read = 32'h2468_ACE0;
        applyStimulus(0, 1'b0, 32'h0000_0100, 32'h0, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("t5_stall%0d", i), 32'(o_req_ready), 32'd0);
        end
        tick();
        checkOutput("t5_stall3", 32'(o_req_ready), 32'd0);
        i_bus_busy = 1'b0;
        tick();
        checkOutput("t5_ready", 32'(o_req_ready), 32'h1);
        checkOutput("t5_error", 32'(o_req_error), 32'd0);
        checkOutput("t5_rdata", o_req_data_read, 32'h2468_ACE0);
        tick();

        // Reset during REQ with both masters pending; pointer was 1
        i_bus_ready = 1'b0;
        applyStimulus(0, 1'b0, 32'h0000_0200, 32'h0, 1);
        applyStimulus(1, 1'b0, 32'h0000_0300, 32'h0, 1);
        tick();
        checkOutput("t6_grant_before", 32'(o_grant), 32'h2);
        tick();
        #2 i_reset_n = 1'b0;
        #1;
        checkOutput("t6_rst_vaild", 32'(o_bus_vaild), 32'd0);
        checkOutput("t6_rst_grant", 32'(o_grant), 32'd0);
        checkOutput("t6_rst_busy", 32'(o_arb_busy), 32'd0);
        checkOutput("t6_rst_addr", o_bus_address, 32'd0);
        checkOutput("t6_rst_rdata", o_req_data_read, 32'd0);
        @(negedge i_clock);
        checkOutput("t6_rst_ready", 32'(o_req_ready), 32'd0);
        #2;
        i_bus_ready = 1'b1;
        i_reset_n = 1'b1;
        tick();
        checkOutput("t6_regrant", 32'(o_grant), 32'h1);
        checkOutput("t6_regrant_addr", o_bus_address, 32'h0000_0200);
        for (int i = 0; i < 20 && (rem[0] > 0 || rem[1] > 0); i++) tick();
        checkOutput("t6_done", 32'(rem[0] + rem[1]), 32'd0);
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
